// File: rtl/led_arbiter.sv
// Round-robin owner of the 8 active-low user LEDs among four requesters.
// Each grant shows its latched pattern, PWM-dimmed, for HOLD_TICKS prescaler ticks.
module led_arbiter #(
    parameter int TICK_DIV   = 133000,
    parameter int HOLD_TICKS = 500,
    parameter int PWM_BITS   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          req_valid,
    input  logic [31:0]         req_data,
    output logic [3:0]          req_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [7:0]          leds,
    output logic [1:0]          owner,
    output logic                busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          last_q, last_d;
    logic [1:0]          owner_q, owner_d;
    logic [7:0]          pattern_q, pattern_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [7:0]          leds_q, leds_d;

    logic                win_valid_s;
    logic [1:0]          win_idx_s;
    logic [3:0]          ready_s;
    logic                tick_s;
    logic                pwm_on_s;

    // Round-robin search starting just after the last winner.
    always_comb begin : arb
        logic [1:0] cand;
        cand        = 2'd0;
        win_valid_s = 1'b0;
        win_idx_s   = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_valid_s && req_valid[cand]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand;
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    assign tick_s   = (state_q == SHOW) && (presc_q == PRESC_MAX);
    assign pwm_on_s = (pwm_q < brightness) | (&brightness);

    // Next-state, grant capture and hold timing.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        pattern_d = pattern_q;
        hold_d    = hold_q;
        presc_d   = presc_q;
        ready_s   = 4'b0000;
        case (state_q)
            IDLE: begin
                if (win_valid_s) begin
                    ready_s   = 4'b0001 << win_idx_s;
                    pattern_d = req_data[{win_idx_s, 3'b000} +: 8];
                    last_d    = win_idx_s;
                    owner_d   = win_idx_s;
                    hold_d    = HOLD_LOAD;
                    presc_d   = '0;
                    state_d   = SHOW;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW: begin
                if (tick_s) begin
                    presc_d = '0;
                    hold_d  = hold_q - HW'(1);
                    if (hold_q == HOLD_LAST) begin
                        state_d = IDLE;
                    end else begin
                        state_d = SHOW;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LEDs are driven off the registered state, so they lag it by one cycle.
    always_comb begin
        leds_d = 8'hFF;
        if (state_q == SHOW) begin
            leds_d = ~(pattern_q & {8{pwm_on_s}});
        end else begin
            leds_d = 8'hFF;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 2'd3;
            owner_q   <= 2'd0;
            pattern_q <= 8'h00;
            hold_q    <= '0;
            presc_q   <= '0;
            pwm_q     <= '0;
            leds_q    <= 8'hFF;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            pattern_q <= pattern_d;
            hold_q    <= hold_d;
            presc_q   <= presc_d;
            pwm_q     <= pwm_q + PWM_BITS'(1);
            leds_q    <= leds_d;
        end
    end

    assign req_ready = reset ? 4'b0000 : ready_s;
    assign leds      = leds_q;
    assign owner     = owner_q;
    assign busy      = (state_q == SHOW);

endmodule
